// File: rtl/alex_relay_spi_if.sv
// Alex relay link bundle: relay-select codes in, SPI header pins and status out.
interface alex_relay_spi_if;
  logic [6:0] LPF;
  logic [5:0] HPF;
  logic [2:0] ctrl;
  logic       SPI_data;
  logic       SPI_clock;
  logic       load_strobe;
  logic       busy;
  logic       settled;

  modport master (
    output LPF, HPF, ctrl,
    input  SPI_data, SPI_clock, load_strobe, busy, settled
  );

  modport slave (
    input  LPF, HPF, ctrl,
    output SPI_data, SPI_clock, load_strobe, busy, settled
  );
endinterface

// File: rtl/alex_relay_spi.sv
// Change-driven serialiser of the 16-bit Alex relay word with latch strobe and settle hold-off.
// Optional periodic re-send of an unchanged word: define ALEX_REFRESH_EN.
module alex_relay_spi #(
  parameter int unsigned CLK_DIV        = 4,
  parameter int unsigned SETTLE_CYCLES  = 1024
`ifdef ALEX_REFRESH_EN
  , parameter int unsigned REFRESH_CYCLES = 4800000
`endif
) (
  input  logic           clock,
  input  logic           reset,
  alex_relay_spi_if.slave alex
);

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_SHIFT_LO = 3'd1;
  localparam logic [2:0] ST_SHIFT_HI = 3'd2;
  localparam logic [2:0] ST_LATCH    = 3'd3;
  localparam logic [2:0] ST_SETTLE   = 3'd4;

  localparam logic [7:0]  DIV_LAST    = 8'(CLK_DIV - 1);
  localparam logic [15:0] SETTLE_LAST = 16'(SETTLE_CYCLES);

  logic [2:0]  r_state;
  logic [7:0]  r_div_cnt;
  logic [15:0] r_settle_cnt;
  logic [3:0]  r_bit_cnt;
  logic [14:0] r_shreg;
  logic [15:0] r_sent_word;
  logic        r_sent_valid;
  logic        r_spi_data;
  logic        r_spi_clock;
  logic        r_load_strobe;
  logic        r_busy;
  logic        r_settled;

  logic [15:0] w_word;
  logic        w_changed;
  logic        w_refresh;
  logic        w_start;
  logic        w_div_done;

  assign w_word     = {alex.ctrl, alex.LPF, alex.HPF};
  assign w_changed  = !r_sent_valid || (w_word != r_sent_word);
  assign w_div_done = (r_div_cnt == DIV_LAST);

`ifdef ALEX_REFRESH_EN
  localparam logic [22:0] REFRESH_LAST = 23'(REFRESH_CYCLES - 1);

  logic [22:0] r_idle_cnt;

  assign w_refresh = (r_state == ST_IDLE) && !w_changed && (r_idle_cnt == REFRESH_LAST);

  // Counts quiet IDLE cycles only; it holds its cleared value through a transfer.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_idle_cnt <= '0;
    end else if (r_state == ST_IDLE) begin
      if (w_changed || w_refresh) r_idle_cnt <= '0;
      else                        r_idle_cnt <= r_idle_cnt + 23'd1;
    end
  end
`else
  assign w_refresh = 1'b0;
`endif

  assign w_start = (r_state == ST_IDLE) && (w_changed || w_refresh);

  // NOTE: every state register uses <= so all of them update from the same pre-edge values.
  always_ff @(posedge clock) begin
    if (reset) begin
      // NOTE: the shift/sent-word datapath is reset too; sent_valid alone would suffice,
      // but a fully defined state keeps post-reset behaviour trivially reproducible.
      r_state       <= ST_IDLE;
      r_div_cnt     <= '0;
      r_settle_cnt  <= '0;
      r_bit_cnt     <= '0;
      r_shreg       <= '0;
      r_sent_word   <= '0;
      r_sent_valid  <= 1'b0;
      r_spi_data    <= 1'b0;
      r_spi_clock   <= 1'b0;
      r_load_strobe <= 1'b0;
      r_busy        <= 1'b0;
      r_settled     <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_start) begin
            r_shreg      <= w_word[14:0];
            r_sent_word  <= w_word;
            r_sent_valid <= 1'b1;
            r_busy       <= 1'b1;
            // A refresh re-sends the same relay state, so the board stays settled.
            if (w_changed) r_settled <= 1'b0;
            r_spi_data   <= w_word[15];
            r_bit_cnt    <= 4'd15;
            r_div_cnt    <= '0;
            r_state      <= ST_SHIFT_LO;
          end
        end

        ST_SHIFT_LO: begin
          if (w_div_done) begin
            r_div_cnt   <= '0;
            r_spi_clock <= 1'b1;
            r_state     <= ST_SHIFT_HI;
          end else begin
            r_div_cnt <= r_div_cnt + 8'd1;
          end
        end

        ST_SHIFT_HI: begin
          if (w_div_done) begin
            r_div_cnt   <= '0;
            r_spi_clock <= 1'b0;
            if (r_bit_cnt != 4'd0) begin
              r_bit_cnt  <= r_bit_cnt - 4'd1;
              r_spi_data <= r_shreg[14];
              r_shreg    <= {r_shreg[13:0], 1'b0};
              r_state    <= ST_SHIFT_LO;
            end else begin
              r_spi_data    <= 1'b0;
              r_load_strobe <= 1'b1;
              r_state       <= ST_LATCH;
            end
          end else begin
            r_div_cnt <= r_div_cnt + 8'd1;
          end
        end

        ST_LATCH: begin
          if (w_div_done) begin
            r_div_cnt     <= '0;
            r_load_strobe <= 1'b0;
            r_settle_cnt  <= '0;
            r_state       <= ST_SETTLE;
          end else begin
            r_div_cnt <= r_div_cnt + 8'd1;
          end
        end

        ST_SETTLE: begin
          // SETTLE_CYCLES counted cycles plus one exit cycle.
          if (r_settle_cnt == SETTLE_LAST) begin
            r_busy    <= 1'b0;
            r_settled <= 1'b1;
            r_state   <= ST_IDLE;
          end else begin
            r_settle_cnt <= r_settle_cnt + 16'd1;
          end
        end

        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign alex.SPI_data    = r_spi_data;
  assign alex.SPI_clock   = r_spi_clock;
  assign alex.load_strobe = r_load_strobe;
  assign alex.busy        = r_busy;
  assign alex.settled     = r_settled;

endmodule

// File: tb/tb_alex_relay_spi.sv
// Self-checking bench for alex_relay_spi: SPI monitor feeding a word scoreboard plus directed sequences.
module tb_alex_relay_spi;

  localparam int CLK_DIV  = 2;
  localparam int SETTLE   = 10;
  localparam int BUSY_LEN = 32 * CLK_DIV + CLK_DIV + SETTLE + 1;

  typedef struct {
    logic [6:0]  lpf;
    logic [5:0]  hpf;
    logic [2:0]  ctrl;
    logic [15:0] word;
  } vec_t;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   total = 0;
  int   bad   = 0;

  alex_relay_spi_if alex ();

  alex_relay_spi #(
    .CLK_DIV       (CLK_DIV),
    .SETTLE_CYCLES (SETTLE)
`ifdef ALEX_REFRESH_EN
    , .REFRESH_CYCLES (200)
`endif
  ) dut (
    .clock (clock),
    .reset (reset),
    .alex  (alex)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  logic [15:0] exp_q[$];

  int          m_edges = 0;
  int          m_total_edges = 0;
  int          m_stable = 0;
  int          m_setup_err = 0;
  int          m_strobe_len = 0;
  int          m_busy_len = 0;
  int          m_settled_low = 0;
  int          n_loads = 0;
  int          n_xfers = 0;
  logic [15:0] m_word = '0;
  logic        p_sck = 1'b0;
  logic        p_ld = 1'b0;
  logic        p_busy = 1'b0;
  logic        p_data = 1'b0;
  longint      cyc = 0;
  longint      rise_t[$];

  always @(posedge clock) cyc++;

  // Monitor: samples the pins mid-cycle, rebuilds each word and scores it at the latch.
  always @(negedge clock) begin
    if (reset) begin
      m_edges = 0; m_word = '0; m_stable = 0; m_setup_err = 0;
      m_strobe_len = 0; m_busy_len = 0;
      p_sck = 1'b0; p_ld = 1'b0; p_busy = 1'b0; p_data = 1'b0;
    end else begin
      if (alex.SPI_clock && !p_sck) begin
        if (m_stable < CLK_DIV || alex.SPI_data !== p_data) m_setup_err++;
        m_word = {m_word[14:0], alex.SPI_data};
        m_edges++;
        m_total_edges++;
      end
      if (alex.SPI_clock) m_stable = 0;
      else m_stable = (alex.SPI_data === p_data) ? m_stable + 1 : 1;

      if (alex.load_strobe) m_strobe_len++;
      if (!alex.load_strobe && p_ld) begin
        n_loads++;
        check("edges_per_word", m_edges, 16);
        check("strobe_len", m_strobe_len, CLK_DIV);
        check("data_setup_errs", m_setup_err, 0);
        if (exp_q.size() == 0) check("queue_depth_at_load", exp_q.size(), 1);
        else check("word", 32'(m_word), 32'(exp_q.pop_front()));
        m_edges = 0; m_word = '0; m_setup_err = 0; m_strobe_len = 0;
      end

      if (alex.busy) m_busy_len++;
      if (alex.busy && !p_busy) rise_t.push_back(cyc);
      if (!alex.busy && p_busy) begin
        n_xfers++;
        check("busy_len", m_busy_len, BUSY_LEN);
        check("settled_after_busy", 32'(alex.settled), 1);
        m_busy_len = 0;
      end
      if (!alex.settled) m_settled_low++;

      p_sck = alex.SPI_clock; p_ld = alex.load_strobe;
      p_busy = alex.busy; p_data = alex.SPI_data;
    end
  end

  task automatic drive(input logic [6:0] l, input logic [5:0] h, input logic [2:0] c);
    alex.LPF = l; alex.HPF = h; alex.ctrl = c;
  endtask

  task automatic wait_xfers(input int target, input int budget, input string name);
    int n = 0;
    while (n_xfers < target && n < budget) begin
      @(negedge clock); #1;
      n++;
    end
    check(name, n_xfers, target);
  endtask

  function automatic logic [31:0] pins();
    return 32'({alex.SPI_data, alex.SPI_clock, alex.load_strobe, alex.busy, alex.settled});
  endfunction

  initial begin
    vec_t vecs[6];
    int   base;
    int   l0;
    int   e0;
    int   n;

    vecs[0] = '{lpf: 7'b0100000, hpf: 6'b000000, ctrl: 3'b101, word: 16'hA800};
    vecs[1] = '{lpf: 7'b0000000, hpf: 6'b111111, ctrl: 3'b000, word: 16'h003F};
    vecs[2] = '{lpf: 7'b1111111, hpf: 6'b000000, ctrl: 3'b000, word: 16'h1FC0};
    vecs[3] = '{lpf: 7'b0000000, hpf: 6'b000000, ctrl: 3'b111, word: 16'hE000};
    vecs[4] = '{lpf: 7'b1000000, hpf: 6'b100001, ctrl: 3'b010, word: 16'h5021};
    vecs[5] = '{lpf: 7'b0101010, hpf: 6'b101010, ctrl: 3'b101, word: 16'hAAAA};

    // Reset values, then the first transfer starts on the first cycle out of reset.
    drive(7'b0001000, 6'b000000, 3'b000);
    reset = 1'b1;
    repeat (3) @(negedge clock);
    #1 check("reset_outputs", pins(), 0);
    exp_q.push_back(16'h0200);
    reset = 1'b0;
    @(negedge clock); #1;
    check("busy_first_cycle", 32'(alex.busy), 1);
    check("first_bit_msb", 32'(alex.SPI_data), 0);
    wait_xfers(1, 200, "xfer_init");
    check("init_settled", 32'(alex.settled), 1);
    check("init_idle_busy", 32'(alex.busy), 0);

`ifndef ALEX_REFRESH_EN
    // Steady inputs: the link stays silent.
    e0 = m_total_edges;
    l0 = n_loads;
    repeat (500) @(negedge clock);
    #1;
    check("steady_edges", m_total_edges - e0, 0);
    check("steady_loads", n_loads - l0, 0);
    check("steady_busy", 32'(alex.busy), 0);
`else
    // Steady inputs: periodic refresh of the unchanged word, settled held high.
    exp_q.push_back(16'h0200);
    exp_q.push_back(16'h0200);
    rise_t.delete();
    m_settled_low = 0;
    wait_xfers(n_xfers + 2, 800, "refresh_xfers");
    if (rise_t.size() >= 2) check("refresh_period", 32'(rise_t[1] - rise_t[0]), 277);
    else check("refresh_starts", rise_t.size(), 2);
    check("refresh_settled_held", m_settled_low, 0);
`endif

    // Table of single-change vectors, each scored by the monitor at its latch.
    for (int i = 0; i < 6; i++) begin
      base = n_xfers;
      drive(vecs[i].lpf, vecs[i].hpf, vecs[i].ctrl);
      exp_q.push_back(vecs[i].word);
      wait_xfers(base + 1, 300, "vec_xfer");
      check("vec_settled", 32'(alex.settled), 1);
    end

    // Changes during busy collapse into one follow-up transfer of the latest word.
    base = n_xfers;
    l0 = n_loads;
    drive(7'b0001000, 6'b000000, 3'b000);
    exp_q.push_back(16'h0200);
    repeat (10) @(negedge clock);
    #1 check("collapse_busy", 32'(alex.busy), 1);
    drive(7'b0000100, 6'b000000, 3'b000);
    repeat (10) @(negedge clock);
    #1 drive(7'b0000010, 6'b000000, 3'b000);
    exp_q.push_back(16'h0080);
    wait_xfers(base + 2, 400, "collapse_xfers");
    repeat (150) @(negedge clock);
    #1 check("collapse_load_count", n_loads - l0, 2);

    // Reset at the 8th SPI rising edge aborts without a latch; the word is re-sent afterwards.
    drive(7'b0000000, 6'b000000, 3'b011);
    exp_q.push_back(16'h6000);
    l0 = n_loads;
    n = 0;
    while (m_edges < 8 && n < 200) begin
      @(negedge clock); #1;
      n++;
    end
    check("abort_at_edge8", m_edges, 8);
    reset = 1'b1;
    @(negedge clock); #1;
    check("abort_outputs", pins(), 0);
    check("abort_no_strobe", n_loads - l0, 0);
    reset = 1'b0;
    base = n_xfers;
    wait_xfers(base + 1, 300, "abort_resend");
    check("abort_resend_loads", n_loads - l0, 1);

    check("queue_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL global_timeout: got time %0t expected end of test", $time);
    $fatal(1, "timeout");
  end

endmodule
